mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   MEM-stage load/store unit between EXMEM and MEMWB. Drives a single-ported data-memory bus.
//   Stores: lane-shifts write data and generates byte strobes. Loads: aligns and sign/zero-extends read data.
//   Holds the pipeline with stall_o while an access is outstanding.
//   Delivers final load data on mem_rdata_o, which feeds MEMWB mem_rdata_i.
// PARAMETERS
//   TIMEOUT     255  max cycles in WAIT before bus error; 8-bit counter, legal range 1..255
// PORTS
//   clk           in   1   clock, rising edge
//   rst_n         in   1   asynchronous reset, active low
//   valid_i       in   1   EXMEM holds a valid instruction
//   mem_read_i    in   1   load instruction
//   mem_write_i   in   1   store instruction
//   funct3_i      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr_i        in   32  byte address (EXMEM alu_out)
//   wdata_i       in   32  store data (rs2)
//   dmem_req_o    out  1   bus request
//   dmem_we_o     out  1   1 = write
//   dmem_addr_o   out  32  {addr_i[31:2],2'b00}
//   dmem_wdata_o  out  32  lane-replicated store data
//   dmem_wstrb_o  out  4   byte enables; 0 for loads
//   dmem_ready_i  in   1   bus completes the access this cycle
//   dmem_rdata_i  in   32  read word, valid when ready
//   mem_rdata_o   out  32  extended load data
//   stall_o       out  1   freeze PC/IFID/IDEX/EXMEM
//   misalign_o    out  1   misaligned access detected (comb, 1 cycle)
//   bus_err_o     out  1   timeout pulse, 1 cycle
// BEHAVIOUR
//   - FSM states:
//       IDLE: access = valid_i & (mem_read_i | mem_write_i) & aligned; drive req comb.
//             ready -> DONE; else -> WAIT.
//       WAIT: req held; ready -> DONE; cnt==TIMEOUT-1 -> ERR.
//       ERR: bus_err_o=1, req=0, rdata reg <= 0 -> DONE.
//       DONE: stall_o=0, req=0 -> IDLE unconditionally; never reissues.
//   - Stall: stall_o=1 in IDLE-with-access, WAIT and ERR; 0 in DONE.
//     Ready in cycle k (k=0 is issue) -> stall cycles 0..k, DONE at k+1.
//   - Bus handshake: req/we/addr/wdata/wstrb stay stable from issue until ready is sampled.
//   - Capture: funct3 and addr[1:0] are registered at issue. Upstream holds inputs stable while stall_o=1.
//   - Read capture: dmem_rdata_i is captured on ready. mem_rdata_o = extend(captured) in DONE; 0 otherwise.
//   - Store lanes:
//       SB: wdata={4{wdata_i[7:0]}}, wstrb=4'b0001<<addr[1:0]
//       SH: wdata={2{wdata_i[15:0]}}, wstrb=4'b0011<<addr[1:0]
//       SW: wdata=wdata_i, wstrb=4'b1111
//   - Load extension: select byte/half at captured addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passthrough.
//   - Misalignment: H/HU with addr[0]=1, or W with addr[1:0]!=0.
//     Response: misalign_o=1, no req, no stall, mem_rdata_o=0, store suppressed.
//   - Read and write both high: treated as write.
//   - valid_i=0: no access; outputs idle.
//   - Timeout counter: 8-bit, zeroed on entering WAIT; saturation impossible given TIMEOUT legal range.
//   - Reset: async assert -> state IDLE, cnt 0, captured data 0.
//     All outputs 0 immediately, including mid-access; the bus must tolerate a dropped req.
// STRUCTURE
//   - Shared header mem_defs.vh: funct3 encodings (F3_B, F3_H, F3_W, F3_BU, F3_HU), FSM state encodings.
//   - Sub-module load_extend (comb): inputs word, funct3, byte offset; output 32-bit extended data.
//   - Store lane logic inline.
// TESTING
//   1. LW 0x100, ready same cycle, rdata 0xDEADBEEF
//      -> req 1 cycle, stall 1 cycle, next cycle mem_rdata_o=0xDEADBEEF, stall 0.
//   2. LB 0x103 rdata 0x80112233 -> 0xFFFFFF80.
//      LBU same -> 0x00000080.
//      LH 0x102 rdata 0x80017777 -> 0xFFFF8001.
//   3. SB 0x101 wdata 0x12345678, ready at k=3
//      -> addr 0x100, wdata 0x78787878, wstrb 0010, all stable 4 cycles, stall 4 cycles then 0.
//   4. LW 0x102 -> misalign_o=1, dmem_req_o=0, stall_o=0, mem_rdata_o=0.
//      SH 0x101 -> misalign_o=1, no write issued.
//   5. TIMEOUT=4, ready never
//      -> WAIT 3 cycles, ERR with bus_err_o pulse, req drops, DONE mem_rdata_o=0, IDLE after.
//   6. rst_n low during WAIT -> req/stall fall asynchronously.
//      After release: IDLE, then LW 0x200 rdata 0x1 completes per test 1.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
//   Shared definitions for the MEM-stage load/store unit: funct3 size
//   encodings, the access FSM state type and the alignment rule.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // funct3[1:0] carries the access size for both signed and unsigned loads.
  // Halfwords need an even address and words a word-aligned address.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// load_extend
//   Combinational load alignment: picks the byte or halfword addressed by
//   the byte offset out of a read word and sign- or zero-extends it.
// Ports
//   word    in  32  read word from the data bus
//   funct3  in  3   load type (B, H, W, BU, HU)
//   offset  in  2   byte offset of the access within the word
//   data    out 32  extended load result
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  output logic [31:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    case (offset)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
    // Halfwords are even-aligned, so only offset[1] matters here.
    sel_half = offset[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    data = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   data = {24'h0, sel_byte};
      F3_H:    data = {{16{sel_half[15]}}, sel_half};
      F3_HU:   data = {16'h0, sel_half};
      F3_W:    data = word;
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage load/store unit between EXMEM and MEMWB driving a single-ported
//   data-memory bus. Stores are lane-replicated with byte strobes; loads are
//   aligned and extended. The pipeline is held with stall_o while an access
//   is outstanding; an access that is not answered within TIMEOUT cycles
//   (counting the issue cycle) ends with a one-cycle bus_err_o pulse.
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   valid_i, mem_read_i, mem_write_i, funct3_i, addr_i, wdata_i
//                                   instruction from EXMEM
//   dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o
//                                   bus request, held stable until ready
//   dmem_ready_i, dmem_rdata_i      bus completion and read word
//   mem_rdata_o                     extended load data (valid in DONE only)
//   stall_o                         freeze PC/IFID/IDEX/EXMEM
//   misalign_o                      misaligned access, no bus traffic
//   bus_err_o                       bus timeout pulse
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_wstrb_o,
  input  logic        dmem_ready_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o
);

  // The issue cycle counts toward the timeout, so WAIT gives up after
  // TIMEOUT-1 cycles; cnt starts at 0 in the first WAIT cycle.
  localparam logic [7:0] CNT_LAST = (TIMEOUT >= 2) ? 8'(TIMEOUT - 2) : 8'd0;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        is_mem, misaligned, access, take, cur_we;
  logic [31:0] lane_wdata, ext;
  logic [3:0]  lane_wstrb;
  logic        we_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  assign is_mem     = valid_i & (mem_read_i | mem_write_i);
  assign misaligned = is_misaligned(funct3_i, addr_i[1:0]);
  // Gating with rst_n keeps every output low while reset is held, even if
  // EXMEM still presents a memory instruction.
  assign access     = rst_n & (state == ST_IDLE) & is_mem & ~misaligned;
  assign cur_we     = (state == ST_IDLE) ? mem_write_i : we_q;
  assign take       = dmem_ready_i & (access | (state == ST_WAIT));

  always_comb begin
    lane_wdata = wdata_i;
    lane_wstrb = 4'b1111;
    case (funct3_i[1:0])
      2'b00: begin
        lane_wdata = {4{wdata_i[7:0]}};
        lane_wstrb = 4'b0001 << addr_i[1:0];
      end
      2'b01: begin
        lane_wdata = {2{wdata_i[15:0]}};
        lane_wstrb = 4'b0011 << addr_i[1:0];
      end
      default: ;
    endcase
  end

  // ---- state / timeout counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state != ST_WAIT) cnt <= 8'd0;
      else                  cnt <= cnt + 8'd1;
    end
  end

  // ---- issue capture: bus fields and load shape, held for the whole access ----
  always_ff @(posedge clk) begin
    if (access) begin
      we_q    <= mem_write_i;
      addr_q  <= {addr_i[31:2], 2'b00};
      wdata_q <= mem_write_i ? lane_wdata : 32'h0;
      wstrb_q <= mem_write_i ? lane_wstrb : 4'h0;
      f3_q    <= funct3_i;
      off_q   <= addr_i[1:0];
    end
  end

  // ---- read capture: stores and timeouts leave zero behind ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rdata_q <= 32'h0;
    else if (state == ST_ERR)  rdata_q <= 32'h0;
    else if (take)             rdata_q <= cur_we ? 32'h0 : dmem_rdata_i;
  end

  load_extend u_load_extend (
    .word   (rdata_q),
    .funct3 (f3_q),
    .offset (off_q),
    .data   (ext)
  );

  always_comb begin
    state_nxt    = state;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    dmem_addr_o  = 32'h0;
    dmem_wdata_o = 32'h0;
    dmem_wstrb_o = 4'h0;
    mem_rdata_o  = 32'h0;
    stall_o      = 1'b0;
    misalign_o   = 1'b0;
    bus_err_o    = 1'b0;
    case (state)
      ST_IDLE: begin
        misalign_o = rst_n & is_mem & misaligned;
        if (access) begin
          dmem_req_o   = 1'b1;
          dmem_we_o    = mem_write_i;
          dmem_addr_o  = {addr_i[31:2], 2'b00};
          dmem_wdata_o = mem_write_i ? lane_wdata : 32'h0;
          dmem_wstrb_o = mem_write_i ? lane_wstrb : 4'h0;
          stall_o      = 1'b1;
          state_nxt    = dmem_ready_i ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        dmem_req_o   = 1'b1;
        dmem_we_o    = we_q;
        dmem_addr_o  = addr_q;
        dmem_wdata_o = wdata_q;
        dmem_wstrb_o = wstrb_q;
        stall_o      = 1'b1;
        if (dmem_ready_i)          state_nxt = ST_DONE;
        else if (cnt == CNT_LAST)  state_nxt = ST_ERR;
      end
      ST_ERR: begin
        bus_err_o = 1'b1;
        stall_o   = 1'b1;
        state_nxt = ST_DONE;
      end
      default: begin
        // DONE: release the pipeline for one cycle; EXMEM still shows the
        // finished instruction, so returning to IDLE never reissues it.
        mem_rdata_o = ext;
        state_nxt   = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Directed bench for mem_access_unit with a scoreboard: stimulus pushes
//   expected bus transactions, load results, misalign and timeout events;
//   a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i, mem_read_i, mem_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, wdata_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_wstrb_o;
  logic        dmem_ready_i;
  logic [31:0] dmem_rdata_i;
  logic [31:0] mem_rdata_o;
  logic        stall_o, misalign_o, bus_err_o;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .funct3_i(funct3_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_wstrb_o(dmem_wstrb_o), .dmem_ready_i(dmem_ready_i),
    .dmem_rdata_i(dmem_rdata_i), .mem_rdata_o(mem_rdata_o),
    .stall_o(stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] done_q[$];
  int          mis_q[$];
  int          err_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event seen with nothing expected", nm);
  endtask

  // ---------------- monitor ----------------
  logic        prev_stall = 1'b0;
  bus_t        mb;
  logic [31:0] md;
  int          mi;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (dmem_req_o && dmem_ready_i) begin
        if (bus_q.size() == 0) unexpected("bus_handshake");
        else begin
          mb = bus_q.pop_front();
          chk("mon_we", 32'(dmem_we_o), 32'(mb.we));
          chk("mon_addr", dmem_addr_o, mb.addr);
          chk("mon_wstrb", 32'(dmem_wstrb_o), 32'(mb.wstrb));
          if (mb.we) chk("mon_wdata", dmem_wdata_o, mb.wdata);
        end
      end
      if (bus_err_o) begin
        if (err_q.size() == 0) unexpected("bus_err");
        else begin
          mi = err_q.pop_front();
          chk("mon_err_req", 32'(dmem_req_o), 32'(0));
          chk("mon_err_stall", 32'(stall_o), 32'(1));
        end
      end
      if (misalign_o) begin
        if (mis_q.size() == 0) unexpected("misalign");
        else begin
          mi = mis_q.pop_front();
          chk("mon_mis_rdata", mem_rdata_o, 32'h0);
          chk("mon_mis_wstrb", 32'(dmem_wstrb_o), 32'(0));
        end
      end
      if (prev_stall && !stall_o) begin
        if (done_q.size() == 0) unexpected("done");
        else begin
          md = done_q.pop_front();
          chk("mon_load_data", mem_rdata_o, md);
        end
      end
      prev_stall = stall_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    valid_i = 1'b1; mem_read_i = rd; mem_write_i = wr;
    funct3_i = f3; addr_i = a; wdata_i = wd;
  endtask

  task automatic idle_in();
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; dmem_ready_i = 1'b0;
  endtask

  // ready_k < 0 means the bus never answers and a timeout is expected.
  task automatic run_access(input string nm, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rdata,
                            input int ready_k, input bus_t eb,
                            input logic [31:0] exp_data);
    int  req_last, stall_n;
    logic err;
    err      = (ready_k < 0);
    req_last = err ? int'(TO) - 1 : ready_k;
    stall_n  = 0;
    if (err) err_q.push_back(1);
    else     bus_q.push_back(eb);
    done_q.push_back(exp_data);
    @(posedge clk); #1;
    drive(rd, wr, f3, a, wd);
    for (int c = 0; c < 40; c++) begin
      dmem_ready_i = (c == ready_k);
      dmem_rdata_i = (c == ready_k) ? rdata : 32'h5A5A_5A5A;
      @(negedge clk);
      if (!stall_o) break;
      stall_n++;
      chk({nm, "/req"}, 32'(dmem_req_o), 32'(c <= req_last));
      if (c <= req_last) begin
        chk({nm, "/addr"}, dmem_addr_o, eb.addr);
        chk({nm, "/we"}, 32'(dmem_we_o), 32'(eb.we));
        chk({nm, "/wstrb"}, 32'(dmem_wstrb_o), 32'(eb.wstrb));
        if (eb.we) chk({nm, "/wdata"}, dmem_wdata_o, eb.wdata);
      end
      chk({nm, "/bus_err"}, 32'(bus_err_o), 32'(err && (c == req_last + 1)));
      chk({nm, "/rdata_stalled"}, mem_rdata_o, 32'h0);
      @(posedge clk); #1;
    end
    chk({nm, "/stall_cycles"}, 32'(stall_n), err ? 32'(TO + 1) : 32'(ready_k + 1));
    chk({nm, "/done_req"}, 32'(dmem_req_o), 32'(0));
    @(posedge clk); #1;
    idle_in();
  endtask

  task automatic run_misalign(input string nm, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd);
    mis_q.push_back(1);
    @(posedge clk); #1;
    drive(rd, wr, f3, a, wd);
    dmem_ready_i = 1'b1;   // a wrongly issued access would complete and be caught
    @(negedge clk);
    chk({nm, "/misalign"}, 32'(misalign_o), 32'(1));
    chk({nm, "/req"}, 32'(dmem_req_o), 32'(0));
    chk({nm, "/stall"}, 32'(stall_o), 32'(0));
    @(posedge clk); #1;
    idle_in();
    @(negedge clk);
    chk({nm, "/after_stall"}, 32'(stall_o), 32'(0));
    chk({nm, "/after_misalign"}, 32'(misalign_o), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    idle_in();
    funct3_i = 3'b000; addr_i = 32'h0; wdata_i = 32'h0; dmem_rdata_i = 32'h0;
    #2;
    chk("reset/req", 32'(dmem_req_o), 32'(0));
    chk("reset/stall", 32'(stall_o), 32'(0));
    chk("reset/rdata", mem_rdata_o, 32'h0);
    chk("reset/bus_err", 32'(bus_err_o), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // valid_i low: memory flags must be ignored
    @(posedge clk); #1;
    valid_i = 1'b0; mem_read_i = 1'b1; dmem_ready_i = 1'b1;
    @(negedge clk);
    chk("novalid/req", 32'(dmem_req_o), 32'(0));
    chk("novalid/stall", 32'(stall_o), 32'(0));
    @(posedge clk); #1;
    idle_in();

    // loads
    run_access("lw_100", 1, 0, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 0,
               '{1'b0, 32'h100, 32'h0, 4'h0}, 32'hDEADBEEF);
    run_access("lb_103", 1, 0, F3_B, 32'h103, 32'h0, 32'h80112233, 0,
               '{1'b0, 32'h100, 32'h0, 4'h0}, 32'hFFFFFF80);
    run_access("lbu_103", 1, 0, F3_BU, 32'h103, 32'h0, 32'h80112233, 1,
               '{1'b0, 32'h100, 32'h0, 4'h0}, 32'h00000080);
    run_access("lh_102", 1, 0, F3_H, 32'h102, 32'h0, 32'h80017777, 0,
               '{1'b0, 32'h100, 32'h0, 4'h0}, 32'hFFFF8001);
    run_access("lhu_102", 1, 0, F3_HU, 32'h102, 32'h0, 32'h80017777, 2,
               '{1'b0, 32'h100, 32'h0, 4'h0}, 32'h00008001);
    run_access("lb_105", 1, 0, F3_B, 32'h105, 32'h0, 32'h11228344, 0,
               '{1'b0, 32'h104, 32'h0, 4'h0}, 32'hFFFFFF83);

    // stores
    run_access("sb_101", 0, 1, F3_B, 32'h101, 32'h12345678, 32'h0, 3,
               '{1'b1, 32'h100, 32'h78787878, 4'b0010}, 32'h0);
    run_access("sh_102", 0, 1, F3_H, 32'h102, 32'h0000ABCD, 32'h0, 1,
               '{1'b1, 32'h100, 32'hABCDABCD, 4'b1100}, 32'h0);
    run_access("sw_rdwr_104", 1, 1, F3_W, 32'h104, 32'hCAFEF00D, 32'h0, 0,
               '{1'b1, 32'h104, 32'hCAFEF00D, 4'b1111}, 32'h0);

    // misaligned
    run_misalign("lw_102", 1, 0, F3_W, 32'h102, 32'h0);
    run_misalign("sh_101", 0, 1, F3_H, 32'h101, 32'h12345678);
    run_misalign("lhu_103", 1, 0, F3_HU, 32'h103, 32'h0);

    // timeout
    run_access("lw_timeout", 1, 0, F3_W, 32'h300, 32'h0, 32'h0, -1,
               '{1'b0, 32'h300, 32'h0, 4'h0}, 32'h0);
    @(negedge clk);
    chk("timeout/idle_stall", 32'(stall_o), 32'(0));

    // asynchronous reset in WAIT
    @(posedge clk); #1;
    drive(1, 0, F3_W, 32'h400, 32'h0);
    dmem_ready_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_wait/req_before", 32'(dmem_req_o), 32'(1));
    chk("rst_wait/stall_before", 32'(stall_o), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wait/req", 32'(dmem_req_o), 32'(0));
    chk("rst_wait/stall", 32'(stall_o), 32'(0));
    chk("rst_wait/rdata", mem_rdata_o, 32'h0);
    @(posedge clk); #1;
    chk("rst_hold/req", 32'(dmem_req_o), 32'(0));
    chk("rst_hold/stall", 32'(stall_o), 32'(0));
    idle_in();
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release/stall", 32'(stall_o), 32'(0));
    run_access("lw_200", 1, 0, F3_W, 32'h200, 32'h0, 32'h00000001, 0,
               '{1'b0, 32'h200, 32'h0, 4'h0}, 32'h00000001);

    repeat (3) @(posedge clk);
    chk("sb/bus_left", 32'(bus_q.size()), 32'(0));
    chk("sb/done_left", 32'(done_q.size()), 32'(0));
    chk("sb/mis_left", 32'(mis_q.size()), 32'(0));
    chk("sb/err_left", 32'(err_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
